mux2_rr_arbiter: RTL and testbench

- Sequences a shared 2:1 byte mux between two requesters, A and B.
- Uses round-robin arbitration with bounded bursts.
- The selected beat is registered onto a single valid/ready output channel, and the current mux select is exported.
- Sits in front of the existing 2:1 mux datapath and owns its select line, so the mux is never driven by software-random sel.

---
 rtl/mux2_rr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin sequencer for a shared 2:1 byte mux.
// Two requesters (A, B) compete for one registered valid/ready output.
// A requester may hold the grant for at most BURST consecutive beats while
// the other one is waiting. The registered source select (y_sel_o) drives
// the mux select line.
// Optional build macro MUX_ARB_GRANT_CNT_EN adds per-requester saturating
// ack counters (a_cnt_o, b_cnt_o).
module mux2_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ack_o,
  input  logic             b_req_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ack_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  output logic             y_sel_o,
  input  logic             y_ready_i
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]      a_cnt_o,
  output logic [15:0]      b_cnt_o
`endif
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             last_b;      // 1 when B held the most recent grant
  logic             accept;
  logic             grant_a, grant_b;

  // Output register stage
  logic             vld_p1;
  logic [WIDTH-1:0] y_data_p1;
  logic             sel_p1;

  // Saturating increment used by the optional ack counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The output register can take a new beat when empty or being drained
  assign accept = !vld_p1 || y_ready_i;

  // Arbitration: next state, burst count and the (single) grant this cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (!reset && accept) begin
      unique case (state)
        IDLE: begin
          // On a tie the requester that did not go last wins
          if (a_req_i && (!b_req_i || last_b)) begin
            grant_a   = 1'b1;
            state_nxt = SERVE_A;
            cnt_nxt   = ONE_C;
          end else if (b_req_i) begin
            grant_b   = 1'b1;
            state_nxt = SERVE_B;
            cnt_nxt   = ONE_C;
          end
        end
        SERVE_A: begin
          if (a_req_i && (beat_cnt < BURST_C)) begin
            grant_a = 1'b1;
            cnt_nxt = beat_cnt + ONE_C;
          end else if (b_req_i) begin
            // Hand over without a bubble; B starts a fresh burst
            grant_b   = 1'b1;
            state_nxt = SERVE_B;
            cnt_nxt   = ONE_C;
          end else if (a_req_i) begin
            // Burst exhausted but nobody else wants the mux
            grant_a = 1'b1;
            cnt_nxt = ONE_C;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        SERVE_B: begin
          if (b_req_i && (beat_cnt < BURST_C)) begin
            grant_b = 1'b1;
            cnt_nxt = beat_cnt + ONE_C;
          end else if (a_req_i) begin
            grant_a   = 1'b1;
            state_nxt = SERVE_A;
            cnt_nxt   = ONE_C;
          end else if (b_req_i) begin
            grant_b = 1'b1;
            cnt_nxt = ONE_C;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign a_ack_o = grant_a;
  assign b_ack_o = grant_b;

  // Arbiter state register; frozen while the output stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_b   <= 1'b1;
    end else if (accept) begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      if (grant_a) last_b <= 1'b0;
      if (grant_b) last_b <= 1'b1;
    end
  end

  // ---- stage p1: registered beat, valid and mux select ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      y_data_p1 <= '0;
      sel_p1    <= 1'b0;
    end else if (accept) begin
      if (grant_a) begin
        vld_p1    <= 1'b1;
        y_data_p1 <= a_data_i;
        sel_p1    <= 1'b0;
      end else if (grant_b) begin
        vld_p1    <= 1'b1;
        y_data_p1 <= b_data_i;
        sel_p1    <= 1'b1;
      end else if (y_ready_i) begin
        vld_p1    <= 1'b0;
      end
    end
  end

  assign y_valid_o = vld_p1;
  assign y_data_o  = y_data_p1;
  assign y_sel_o   = sel_p1;

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [15:0] a_cnt, b_cnt;

  // Per-requester ack counters; acks never occur during a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= 16'd0;
      b_cnt <= 16'd0;
    end else begin
      if (grant_a) a_cnt <= sat_inc16(a_cnt);
      if (grant_b) b_cnt <= sat_inc16(b_cnt);
    end
  end

  assign a_cnt_o = a_cnt;
  assign b_cnt_o = b_cnt;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: two instances (BURST=4 and BURST=1) share the
// same requester stimulus; each is compared every cycle to its own
// reference model, plus directed grant-sequence checks.
`timescale 1ns/1ps
module tb_mux2_rr_arbiter;

  localparam int W = 8;
  localparam int BL [2] = '{4, 1};

  logic         clk = 1'b0;
  logic         reset;
  logic         a_req, b_req, y_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ack   [2];
  logic         b_ack   [2];
  logic         y_valid [2];
  logic [W-1:0] y_data  [2];
  logic         y_sel   [2];
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [15:0]  a_cnt   [2];
  logic [15:0]  b_cnt   [2];
`endif

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(W), .BURST(4)) dut0 (
    .clk(clk), .reset(reset),
    .a_req_i(a_req), .a_data_i(a_data), .a_ack_o(a_ack[0]),
    .b_req_i(b_req), .b_data_i(b_data), .b_ack_o(b_ack[0]),
    .y_valid_o(y_valid[0]), .y_data_o(y_data[0]), .y_sel_o(y_sel[0]),
    .y_ready_i(y_ready)
`ifdef MUX_ARB_GRANT_CNT_EN
    , .a_cnt_o(a_cnt[0]), .b_cnt_o(b_cnt[0])
`endif
  );

  mux2_rr_arbiter #(.WIDTH(W), .BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .a_req_i(a_req), .a_data_i(a_data), .a_ack_o(a_ack[1]),
    .b_req_i(b_req), .b_data_i(b_data), .b_ack_o(b_ack[1]),
    .y_valid_o(y_valid[1]), .y_data_o(y_data[1]), .y_sel_o(y_sel[1]),
    .y_ready_i(y_ready)
`ifdef MUX_ARB_GRANT_CNT_EN
    , .a_cnt_o(a_cnt[1]), .b_cnt_o(b_cnt[1])
`endif
  );

  int total = 0;
  int bad   = 0;

  // Requester beat queues (driven by instance 0's acks) and enables
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit           a_en = 1'b1;
  bit           b_en = 1'b1;
  int           glog0[$];
  int           glog1[$];

  // Reference model: who owns the mux (0 none, 1 A, 2 B) and for how long
  bit           m_valid [2];
  logic [W-1:0] m_data  [2];
  bit           m_sel   [2];
  int           m_last  [2];
  int           m_owner [2];
  int           m_run   [2];
  int           m_acnt  [2];
  int           m_bcnt  [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int predict(int i);
    int own;
    bit oreq, xreq;
    if (reset) return 0;
    if (m_valid[i] && !y_ready) return 0;
    if (m_owner[i] == 0) begin
      if (a_req && b_req) return (m_last[i] == 1) ? 2 : 1;
      if (a_req) return 1;
      if (b_req) return 2;
      return 0;
    end
    own  = m_owner[i];
    oreq = (own == 1) ? a_req : b_req;
    xreq = (own == 1) ? b_req : a_req;
    if (oreq && m_run[i] < BL[i]) return own;
    if (xreq) return 3 - own;
    if (oreq) return own;
    return 0;
  endfunction

  task automatic model_edge(int i, int gr);
    if (reset) begin
      m_valid[i] = 0; m_data[i] = '0; m_sel[i] = 0;
      m_last[i] = 2; m_owner[i] = 0; m_run[i] = 0;
      m_acnt[i] = 0; m_bcnt[i] = 0;
    end else if (!m_valid[i] || y_ready) begin
      if (gr != 0) begin
        m_data[i]  = (gr == 1) ? a_data : b_data;
        m_sel[i]   = (gr == 2);
        m_valid[i] = 1;
        m_run[i]   = (gr == m_owner[i] && m_run[i] < BL[i]) ? m_run[i] + 1 : 1;
        m_owner[i] = gr;
        m_last[i]  = gr;
        if (gr == 1 && m_acnt[i] < 16'hFFFF) m_acnt[i]++;
        if (gr == 2 && m_bcnt[i] < 16'hFFFF) m_bcnt[i]++;
      end else begin
        m_owner[i] = 0;
        m_run[i]   = 0;
        if (y_ready) m_valid[i] = 0;
      end
    end
  endtask

  // One clock: drive requests, check acks, clock, check registered outputs
  task automatic cycle();
    int  gr [2];
    bit  pop_a, pop_b;
    a_req = a_en && (qa.size() > 0);
    b_req = b_en && (qb.size() > 0);
    if (qa.size() > 0) a_data = qa[0];
    if (qb.size() > 0) b_data = qb[0];
    #1;
    for (int i = 0; i < 2; i++) begin
      gr[i] = predict(i);
      check($sformatf("a_ack[%0d]", i), 32'(a_ack[i]), 32'(gr[i] == 1));
      check($sformatf("b_ack[%0d]", i), 32'(b_ack[i]), 32'(gr[i] == 2));
    end
    glog0.push_back((a_ack[0] ? 1 : 0) + (b_ack[0] ? 2 : 0));
    glog1.push_back((a_ack[1] ? 1 : 0) + (b_ack[1] ? 2 : 0));
    pop_a = a_ack[0];
    pop_b = b_ack[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, gr[i]);
    #1;
    if (pop_a && qa.size() > 0) void'(qa.pop_front());
    if (pop_b && qb.size() > 0) void'(qb.pop_front());
    for (int i = 0; i < 2; i++) begin
      check($sformatf("y_valid[%0d]", i), 32'(y_valid[i]), 32'(m_valid[i]));
      check($sformatf("y_data[%0d]", i), 32'(y_data[i]), 32'(m_data[i]));
      check($sformatf("y_sel[%0d]", i), 32'(y_sel[i]), 32'(m_sel[i]));
`ifdef MUX_ARB_GRANT_CNT_EN
      check($sformatf("a_cnt[%0d]", i), 32'(a_cnt[i]), 32'(m_acnt[i]));
      check($sformatf("b_cnt[%0d]", i), 32'(b_cnt[i]), 32'(m_bcnt[i]));
`endif
    end
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Compare a logged grant sequence against a string of A/B/'.'
  task automatic check_seq(string tag, int inst, string exp);
    for (int k = 0; k < exp.len(); k++) begin
      int want;
      int got;
      want = (exp[k] == "A") ? 1 : (exp[k] == "B") ? 2 : 0;
      if (inst == 0) got = (k < glog0.size()) ? glog0[k] : 99;
      else           got = (k < glog1.size()) ? glog1[k] : 99;
      check($sformatf("%s_beat%0d", tag, k), 32'(got), 32'(want));
    end
  endtask

  task automatic clear_log();
    glog0.delete();
    glog1.delete();
  endtask

  initial begin
    reset = 1'b1; y_ready = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_data = '0; b_data = '0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_data[i] = '0; m_sel[i] = 0; m_last[i] = 2;
      m_owner[i] = 0; m_run[i] = 0; m_acnt[i] = 0; m_bcnt[i] = 0;
    end

    // Reset state
    run(2);
    reset = 1'b0;

    // Contention from reset: BURST=4 gives AAAABBBBAAAA, BURST=1 alternates
    clear_log();
    for (int k = 0; k < 20; k++) begin
      qa.push_back(8'(8'h40 + k));
      qb.push_back(8'(8'h80 + k));
    end
    run(12);
    check_seq("contend_b4", 0, "AAAABBBBAAAA");
    check_seq("tie_b1", 1, "ABABABABABAB");
    qa.delete(); qb.delete();
    run(3);

    // Single requester streaming, no backpressure
    clear_log();
    qa.push_back(8'h11); qa.push_back(8'h22); qa.push_back(8'h33);
    run(5);
    check_seq("single_a", 0, "AAA..");

    // Backpressure: hold 5A while B waits
    qa.push_back(8'h5A);
    run(1);
    y_ready = 1'b0;
    qb.push_back(8'h77);
    clear_log();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_hold_data", 32'(y_data[0]), 32'h5A);
    end
    check_seq("bp_stall", 0, "...");
    y_ready = 1'b1;
    clear_log();
    cycle();
    check_seq("bp_release", 0, "B");
    check("bp_new_data", 32'(y_data[0]), 32'h77);
    run(3);

    // Early release: A drops after 2 beats, B gets a fresh 4-beat burst
    clear_log();
    qa.push_back(8'hA1); qa.push_back(8'hA2);
    for (int k = 0; k < 6; k++) qb.push_back(8'(8'hB1 + k));
    run(3);
    qa.push_back(8'hA3); qa.push_back(8'hA4);
    run(5);
    check_seq("early_rel", 0, "AABBBBAA");
    run(4);
    qa.delete(); qb.delete();
    run(2);

    // Reset in the middle of a B burst
    for (int k = 0; k < 4; k++) qb.push_back(8'(8'hD0 + k));
    run(2);
    reset = 1'b1;
    clear_log();
    cycle();
    reset = 1'b0;
    check_seq("rst_noack", 0, ".");
    check("rst_y_valid", 32'(y_valid[0]), 32'd0);
    check("rst_y_data", 32'(y_data[0]), 32'd0);
    check("rst_y_sel", 32'(y_sel[0]), 32'd0);
`ifdef MUX_ARB_GRANT_CNT_EN
    check("rst_a_cnt", 32'(a_cnt[0]), 32'd0);
    check("rst_b_cnt", 32'(b_cnt[0]), 32'd0);
`endif
    qa.push_back(8'hC1);
    clear_log();
    cycle();
    check_seq("rst_tie", 0, "A");
    check_seq("rst_tie_b1", 1, "A");
    qa.delete(); qb.delete();
    run(3);

    // Randomized traffic with backpressure and withdrawn requests
    for (int c = 0; c < 600; c++) begin
      y_ready = ($urandom_range(0, 9) < 7);
      if (qa.size() < 3 && $urandom_range(0, 2) == 0) qa.push_back(8'($urandom));
      if (qb.size() < 3 && $urandom_range(0, 2) == 0) qb.push_back(8'($urandom));
      a_en = ($urandom_range(0, 9) != 0);
      b_en = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
